// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch PC generator.
//   FETCH_ADDR_W   - default PC / address width
//   FETCH_STEP     - default sequential fetch increment in bytes
//   FETCH_RESET_PC - default PC held during reset (truncated to ADDR_W by users)
//   next_src_e     - source chosen for the next fetch PC
package fetch_pkg;

    localparam int          FETCH_ADDR_W   = 32;
    localparam int          FETCH_STEP     = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0040_0000;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_TAKEN,
        SRC_JUMP,
        SRC_PEND,
        SRC_RAS
    } next_src_e;

endpackage

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return-address stack.
// Ports:
//   clk, reset      - clock, async active-high reset (clears count only)
//   push, data      - push data onto the stack; on a full stack the oldest
//                     entry is overwritten and the count saturates at DEPTH
//   pop             - drop the top entry; ignored when empty
//   top             - current top entry (valid when !empty)
//   empty, full     - occupancy flags
// push and pop together replace the top entry in place (count unchanged).
module ret_addr_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [IDX_W-1:0] topIdx;
    logic [IDX_W-1:0] upIdx;
    logic [IDX_W-1:0] downIdx;
    logic [CNT_W-1:0] count;
    logic             doPop;

    // Explicit wrap so non-power-of-two depths stay circular.
    assign upIdx   = (topIdx == LAST_IDX) ? '0 : topIdx + IDX_W'(1);
    assign downIdx = (topIdx == '0) ? LAST_IDX : topIdx - IDX_W'(1);

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign doPop = pop && !empty;
    assign top   = mem[topIdx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            topIdx <= '0;
            count  <= '0;
        end else if (push && !doPop) begin
            topIdx <= upIdx;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (doPop && !push) begin
            topIdx <= downIdx;
            count  <= count - CNT_W'(1);
        end
    end

    // Entry contents need no reset; only the count defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[doPop ? topIdx : upIdx] <= data;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch program-counter generator.
// Next PC priority: jump > taken branch > pending redirect > RAS pop > PC+STEP.
// Redirects seen during a stall are held in a pending register (last wins,
// jump over taken) and applied on the first unstalled cycle unless a fresh
// redirect arrives in that same cycle.
// Build option: define RAS_PREDICT_EN to build the return-address stack;
// otherwise call_i/ret_i/linkAddr_i are ignored and rasHit_o is 0.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   stall_i                    - hold PC
//   taken_i, branchTarget_i    - taken branch redirect
//   jump_i, jumpAddr_i         - jump redirect
//   call_i, linkAddr_i         - push return address (RAS builds)
//   ret_i                      - pop and redirect (RAS builds)
//   pc_o                       - registered fetch PC
//   pendingValid_o             - redirect latched, waiting for stall release
//   rasHit_o                   - last PC update came from the RAS
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = FETCH_ADDR_W,
    parameter int          STEP      = FETCH_STEP,
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              taken_i,
    input  logic [ADDR_W-1:0] branchTarget_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jumpAddr_i,
    input  logic              call_i,
    input  logic [ADDR_W-1:0] linkAddr_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pendingValid_o,
    output logic              rasHit_o
);

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pcQ;
    logic [ADDR_W-1:0] pendPcQ;
    logic              pendValidQ;
    logic              redirect;
    logic [ADDR_W-1:0] redirTarget;
    logic              rasAvail;
    logic [ADDR_W-1:0] rasTop;
    next_src_e         nextSrc;
    logic [ADDR_W-1:0] nextPc;

    assign redirect    = jump_i || taken_i;
    assign redirTarget = jump_i ? jumpAddr_i : branchTarget_i;

    always_comb begin
        nextSrc = SRC_SEQ;
        if (jump_i) begin
            nextSrc = SRC_JUMP;
        end else if (taken_i) begin
            nextSrc = SRC_TAKEN;
        end else if (pendValidQ) begin
            nextSrc = SRC_PEND;
        end else if (rasAvail) begin
            nextSrc = SRC_RAS;
        end
    end

    always_comb begin
        nextPc = pcQ + ADDR_W'(STEP);
        case (nextSrc)
            SRC_JUMP:  nextPc = jumpAddr_i;
            SRC_TAKEN: nextPc = branchTarget_i;
            SRC_PEND:  nextPc = pendPcQ;
            SRC_RAS:   nextPc = rasTop;
            default:   nextPc = pcQ + ADDR_W'(STEP);
        endcase
    end

    // Any PC update consumes the pending redirect, whether or not it was used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcQ        <= RESET_PC_W;
            pendPcQ    <= '0;
            pendValidQ <= 1'b0;
        end else if (!stall_i) begin
            pcQ        <= nextPc;
            pendValidQ <= 1'b0;
        end else if (redirect) begin
            pendPcQ    <= redirTarget;
            pendValidQ <= 1'b1;
        end
    end

    assign pc_o           = pcQ;
    assign pendingValid_o = pendValidQ;

`ifdef RAS_PREDICT_EN
    logic              rasPush;
    logic              rasPop;
    logic              rasEmpty;
    logic              unusedRasFull;
    logic [ADDR_W-1:0] rasTopData;
    logic              rasHitQ;

    // The pop happens even when a jump/taken redirect wins the PC.
    assign rasPush  = !stall_i && call_i;
    assign rasPop   = !stall_i && ret_i;
    assign rasAvail = ret_i && !rasEmpty;
    assign rasTop   = rasTopData;

    ret_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) uRas (
        .clk   (clk),
        .reset (reset),
        .push  (rasPush),
        .pop   (rasPop),
        .data  (linkAddr_i),
        .top   (rasTopData),
        .empty (rasEmpty),
        .full  (unusedRasFull)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rasHitQ <= 1'b0;
        end else begin
            rasHitQ <= !stall_i && (nextSrc == SRC_RAS);
        end
    end

    assign rasHit_o = rasHitQ;
`else
    logic unusedRasInputs;
    localparam int unusedRasDepth = RAS_DEPTH;

    assign rasAvail        = 1'b0;
    assign rasTop          = '0;
    assign rasHit_o        = 1'b0;
    assign unusedRasInputs = ^{call_i, ret_i, linkAddr_i};
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed, table-driven bench for fetch_pc_gen.
// A 32-bit instance covers sequencing, stall/pending and reset behaviour;
// an 8-bit instance covers wrap-around and RESET_PC truncation.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        taken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpAddr;
    logic        call;
    logic [31:0] linkAddr;
    logic        ret;
    logic [31:0] pc;
    logic        pendingValid;
    logic        rasHit;

    logic        stall8;
    logic [7:0]  pc8;
    logic        pendingValid8;
    logic        rasHit8;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(
        .ADDR_W    (32),
        .STEP      (4),
        .RESET_PC  (32'h0040_0000),
        .RAS_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall),
        .taken_i        (taken),
        .branchTarget_i (branchTarget),
        .jump_i         (jump),
        .jumpAddr_i     (jumpAddr),
        .call_i         (call),
        .linkAddr_i     (linkAddr),
        .ret_i          (ret),
        .pc_o           (pc),
        .pendingValid_o (pendingValid),
        .rasHit_o       (rasHit)
    );

    fetch_pc_gen #(
        .ADDR_W    (8),
        .STEP      (4),
        .RESET_PC  (32'hABCD_EFFC),
        .RAS_DEPTH (2)
    ) dut8 (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall8),
        .taken_i        (1'b0),
        .branchTarget_i (8'h00),
        .jump_i         (1'b0),
        .jumpAddr_i     (8'h00),
        .call_i         (1'b0),
        .linkAddr_i     (8'h00),
        .ret_i          (1'b0),
        .pc_o           (pc8),
        .pendingValid_o (pendingValid8),
        .rasHit_o       (rasHit8)
    );

    typedef struct {
        logic        st;
        logic        tk;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] ja;
        logic [31:0] expPc;
        logic        expPend;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic st, input logic tk, input logic [31:0] bt,
                         input logic jp, input logic [31:0] ja,
                         input logic cl, input logic rt, input logic [31:0] lk);
        @(negedge clk);
        stall        = st;
        taken        = tk;
        branchTarget = bt;
        jump         = jp;
        jumpAddr     = ja;
        call         = cl;
        ret          = rt;
        linkAddr     = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic stepChk(input string name, input logic st, input logic tk, input logic [31:0] bt,
                           input logic jp, input logic [31:0] ja,
                           input logic cl, input logic rt, input logic [31:0] lk,
                           input logic [31:0] expPc, input logic expPend, input logic expHit);
        cycle(st, tk, bt, jp, ja, cl, rt, lk);
        check({name, "_pc"}, pc, expPc);
        check({name, "_pend"}, {31'b0, pendingValid}, {31'b0, expPend});
        check({name, "_hit"}, {31'b0, rasHit}, {31'b0, expHit});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            st    tk    bt             jp    ja             expPc          pend
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0004, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0008, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_000C, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0010, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0,         32'h0040_0010, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0200, 32'h0040_0010, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0200, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0040_0600, 1'b1, 32'h0040_0500, 32'h0040_0200, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0500, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0,         32'h0040_0500, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h0040_0300, 1'b0, 32'h0,         32'h0040_0300, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0304, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_1000, 32'h0000_1000, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0,         32'h0000_3000, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_3000, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_3004, 1'b0};

        reset        = 1'b1;
        stall        = 1'b1;
        stall8       = 1'b1;
        taken        = 1'b0;
        branchTarget = '0;
        jump         = 1'b0;
        jumpAddr     = '0;
        call         = 1'b0;
        ret          = 1'b0;
        linkAddr     = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 32'h0040_0000);
        check("reset_pend", {31'b0, pendingValid}, 32'h0);
        check("reset_hit", {31'b0, rasHit}, 32'h0);
        check("reset_pc8", {24'h0, pc8}, 32'h0000_00FC);

        // Release reset while stalled: PC must still sit at RESET_PC.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("release_hold_pc", pc, 32'h0040_0000);

        for (int i = 0; i < 16; i++) begin
            stepChk($sformatf("vec%0d", i), vecs[i].st, vecs[i].tk, vecs[i].bt,
                    vecs[i].jp, vecs[i].ja, 1'b0, 1'b0, 32'h0,
                    vecs[i].expPc, vecs[i].expPend, 1'b0);
        end

        // Reset during a stall with a redirect pending.
        stepChk("midstall_pend", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0700, 1'b0, 1'b0, 32'h0,
                32'h0000_3004, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midstall_reset_pc", pc, 32'h0040_0000);
        check("midstall_reset_pend", {31'b0, pendingValid}, 32'h0);
        check("midstall_reset_pc8", {24'h0, pc8}, 32'h0000_00FC);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        jump  = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_pc", pc, 32'h0040_0004);
        check("post_reset_pend", {31'b0, pendingValid}, 32'h0);

        // 8-bit instance: 0xFC + 4 wraps to 0x00; main instance held stalled.
        @(negedge clk);
        stall  = 1'b1;
        stall8 = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_pc8", {24'h0, pc8}, 32'h0);
        check("wrap_hold_pc", pc, 32'h0040_0004);
        @(negedge clk);
        stall8 = 1'b1;
        @(posedge clk);
        #1;
        check("wrap_hold_pc8", {24'h0, pc8}, 32'h0);
        check("wrap_pend8", {31'b0, pendingValid8}, 32'h0);
        check("wrap_hit8", {31'b0, rasHit8}, 32'h0);

`ifdef RAS_PREDICT_EN
        stepChk("call10", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0040_0008, 1'b0, 1'b0);
        stepChk("call20", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0040_000C, 1'b0, 1'b0);
        stepChk("call30", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0040_0010, 1'b0, 1'b0);
        stepChk("ret1",   1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'h0000_0030, 1'b0, 1'b1);
        stepChk("ret2",   1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'h0000_0020, 1'b0, 1'b1);
        stepChk("ret3",   1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'h0000_0024, 1'b0, 1'b0);
        stepChk("call40", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0000_0028, 1'b0, 1'b0);
        stepChk("callret",1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h50, 32'h0000_0040, 1'b0, 1'b1);
        stepChk("ret50",  1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'h0000_0050, 1'b0, 1'b1);
        stepChk("retempty",1'b0,1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'h0000_0054, 1'b0, 1'b0);
        stepChk("call60", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0000_0058, 1'b0, 1'b0);
        stepChk("retjump",1'b0, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0, 1'b1, 32'h0, 32'h0000_0900, 1'b0, 1'b0);
        stepChk("retpopped",1'b0,1'b0,32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'h0000_0904, 1'b0, 1'b0);
        stepChk("stallcall",1'b1,1'b0,32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h70, 32'h0000_0904, 1'b0, 1'b0);
        stepChk("retnopush",1'b0,1'b0,32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'h0000_0908, 1'b0, 1'b0);
`else
        stepChk("norascall", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0040_0008, 1'b0, 1'b0);
        stepChk("norasret",  1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'h0040_000C, 1'b0, 1'b0);
        stepChk("norasboth", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h0040_0010, 1'b0, 1'b0);
        stepChk("norasseq",  1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0040_0014, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32: PC and all address widths.
REQ-002 Parameter STEP, default 4: sequential increment in bytes.
REQ-003 Parameter RESET_PC, default 32'h0040_0000, truncated to ADDR_W: PC value held during reset.
REQ-004 Parameter RAS_DEPTH, default 4, legal range 2..16: return-address-stack entries.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 stall_i  in  1  combined fetch stall (branch, load or syscall); PC holds while high.
REQ-008 taken_i  in  1  branch resolved taken; target on branchTarget_i.
REQ-009 branchTarget_i  in  ADDR_W  branch target.
REQ-010 jump_i  in  1  jump redirect; target on jumpAddr_i.
REQ-011 jumpAddr_i  in  ADDR_W  jump target.
REQ-012 call_i  in  1  call decoded; push linkAddr_i (RAS builds only).
REQ-013 linkAddr_i  in  ADDR_W  return address to push.
REQ-014 ret_i  in  1  return decoded; pop and redirect (RAS builds only).
REQ-015 pc_o  out  ADDR_W  current fetch PC, registered.
REQ-016 pendingValid_o  out  1  a redirect is latched and awaiting stall release.
REQ-017 rasHit_o  out  1  registered; high for one cycle after a PC update sourced from the RAS.

Function
REQ-018 The next PC SHALL be selected by fixed priority: jump_i > taken_i > pending redirect > RAS pop > pc_o+STEP.
REQ-019 pc_o+STEP SHALL wrap modulo 2^ADDR_W; no carry-out is reported.
REQ-020 With stall_i low, pc_o SHALL load the selected next PC on the next posedge (1-cycle latency).
REQ-021 With stall_i high, pc_o SHALL hold.
REQ-022 A jump or taken redirect arriving while stall_i is high SHALL be latched into the pending register, with jump winning over taken.
REQ-023 A later redirect during the same stall SHALL overwrite the pending value (last wins).
REQ-024 On the first unstalled cycle, pc_o SHALL load the pending value unless a new jump or taken redirect is present in that cycle; the new redirect wins and the pending value is discarded.
REQ-025 pendingValid_o SHALL clear on the posedge at which pc_o updates.
REQ-026 call_i and ret_i SHALL be acted on only in unstalled cycles.
REQ-027 ret_i on an empty RAS SHALL cause no pop and no redirect.
REQ-028 call_i on a full RAS SHALL overwrite the oldest entry (circular); the count saturates at RAS_DEPTH.
REQ-029 call_i and ret_i in the same cycle SHALL redirect to the old top and replace the top with linkAddr_i; the count is unchanged.
REQ-030 If ret_i coincides with jump_i or taken_i, the pop SHALL still occur but the redirect SHALL use the higher-priority source, and rasHit_o SHALL stay low.

Reset
REQ-031 While reset is high: pc_o = RESET_PC, pendingValid_o = 0, rasHit_o = 0, RAS count = 0 (entry contents don't-care).
REQ-032 Reset asserted mid-stall SHALL discard any pending redirect.
REQ-033 After reset deasserts, the first unstalled posedge SHALL produce pc_o = RESET_PC+STEP.

Configuration
REQ-034 Macro RAS_PREDICT_EN: when defined, the RAS and the behaviour in REQ-027..030 are built.
REQ-035 When RAS_PREDICT_EN is undefined: call_i, ret_i and linkAddr_i are ignored, no stack storage exists, and rasHit_o is tied to 0.

Structure
REQ-036 Shared package fetch_pkg SHALL hold the default ADDR_W and STEP, RESET_PC, and the enum next_src_e {SRC_SEQ, SRC_TAKEN, SRC_JUMP, SRC_PEND, SRC_RAS}.
REQ-037 The RAS SHALL be the sub-module ret_addr_stack, with push/pop/data/empty/full ports, instantiated only under RAS_PREDICT_EN.

Verification
REQ-038 Reset, then 3 unstalled cycles -> pc_o = 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
REQ-039 PC 0x00400010: stall 2 cycles, taken_i=1 with target 0x00400100 in stall cycle 1, jump_i=1 with 0x00400200 in stall cycle 2 -> pendingValid_o=1; pc_o=0x00400200 after release, then pendingValid_o=0.
REQ-040 Pending 0x00400100; release cycle carries taken_i=1 with target 0x00400300 -> pc_o = 0x00400300.
REQ-041 ADDR_W=8, STEP=4, pc_o=0xFC, unstalled -> pc_o = 0x00.
REQ-042 RAS_PREDICT_EN, RAS_DEPTH=2: push 0x10, 0x20, 0x30, then ret x3 -> redirects 0x30, then 0x20 (rasHit_o=1 each), third ret gives sequential PC with rasHit_o=0.
REQ-043 Build without RAS_PREDICT_EN: call_i then ret_i -> sequential PC only; rasHit_o stays 0.
